rx_frame_ctrl: RTL and testbench

- Receive-side sequencer for the Bluetooth UART path. It owns the UART_rcv handshake (rx_rdy/clr_rx_rdy) and assembles bytes into 4-byte command frames: SOF, CMD, ARG, CHK.
- Each checked frame is held in a one-entry output register for the downstream consumer (auth/config logic) until that consumer acknowledges it.
- It reports checksum errors, inter-byte timeouts and overwrite of an unacknowledged frame.

---
 rtl/rx_frame_ctrl_if.sv | 21 ++
 rtl/rx_frame_ctrl.sv | 72 +++++++
 tb/tb_rx_frame_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rx_frame_ctrl_if.sv
// rx_frame_ctrl_if: UART_rcv byte handshake plus held-frame outputs toward the consumer.
interface rx_frame_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       clr_rx_rdy;
    logic [7:0] cmd;
    logic [7:0] arg;
    logic       cmd_vld;
    logic       cmd_ack;
    logic       frm_err;
    logic       to_err;
    logic       ovr_err;
    modport master (
        output rx_data, rx_rdy, cmd_ack,
        input  clr_rx_rdy, cmd, arg, cmd_vld, frm_err, to_err, ovr_err
    );
    modport slave (
        input  rx_data, rx_rdy, cmd_ack,
        output clr_rx_rdy, cmd, arg, cmd_vld, frm_err, to_err, ovr_err
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: assembles SOF/CMD/ARG/CHK frames from UART_rcv into a one-entry held register.
module rx_frame_ctrl #(
    parameter logic [7:0] SOF    = 8'hA5,
    parameter int         TO_CYC = 100000,
    parameter int         TO_W   = 17
) (
    input logic           clk,
    input logic           rst,
    rx_frame_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GET_CMD, GET_ARG, GET_CHK} state_t;
    state_t          state;
    logic [TO_W-1:0] cnt;
    logic [7:0]      cmd_tmp;
    logic [7:0]      arg_tmp;
    logic [7:0]      sum;
    assign sum            = cmd_tmp + arg_tmp;
    assign bus.clr_rx_rdy = bus.rx_rdy & ~rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cmd_tmp     <= 8'h00;
            arg_tmp     <= 8'h00;
            bus.cmd     <= 8'h00;
            bus.arg     <= 8'h00;
            bus.cmd_vld <= 1'b0;
            bus.frm_err <= 1'b0;
            bus.to_err  <= 1'b0;
            bus.ovr_err <= 1'b0;
        end else begin
            bus.frm_err <= 1'b0;
            bus.to_err  <= 1'b0;
            bus.ovr_err <= 1'b0;
            if (bus.cmd_ack) bus.cmd_vld <= 1'b0;
            if (bus.rx_rdy) begin
                cnt <= '0;
                case (state)
                    IDLE: if (bus.rx_data == SOF) state <= GET_CMD;
                    GET_CMD: begin
                        cmd_tmp <= bus.rx_data;
                        state   <= GET_ARG;
                    end
                    GET_ARG: begin
                        arg_tmp <= bus.rx_data;
                        state   <= GET_CHK;
                    end
                    default: begin
                        state <= IDLE;
                        if (bus.rx_data == sum) begin
                            bus.cmd     <= cmd_tmp;
                            bus.arg     <= arg_tmp;
                            bus.cmd_vld <= 1'b1;
                            // a same-cycle ack retires the old frame, so nothing is lost
                            bus.ovr_err <= bus.cmd_vld & ~bus.cmd_ack;
                        end else begin
                            bus.frm_err <= 1'b1;
                        end
                    end
                endcase
            end else if (state == IDLE) begin
                cnt <= '0;
            end else if (cnt == TO_W'(TO_CYC - 1)) begin
                state      <= IDLE;
                cnt        <= '0;
                bus.to_err <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed frames with hand-computed expectations, TO_CYC shortened to 16.
module tb_rx_frame_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;
    int   clr_cnt = 0;
    int   frm_cnt = 0;
    int   to_cnt = 0;
    int   ovr_cnt = 0;
    rx_frame_ctrl_if bus ();
    rx_frame_ctrl #(.SOF(8'hA5), .TO_CYC(16), .TO_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.clr_rx_rdy) clr_cnt++;
        if (bus.frm_err) frm_cnt++;
        if (bus.to_err) to_cnt++;
        if (bus.ovr_err) ovr_cnt++;
    end
    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        #1;
        chk("clr_rx_rdy", int'(bus.clr_rx_rdy), 1);
        @(posedge clk);
        #1;
        bus.rx_rdy = 1'b0;
    endtask
    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask
    task automatic ack();
        bus.cmd_ack = 1'b1;
        idle(1);
        bus.cmd_ack = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.rx_data = 8'h00;
        bus.rx_rdy  = 1'b1;
        bus.cmd_ack = 1'b0;
        idle(3);
        chk("rst clr_rx_rdy", int'(bus.clr_rx_rdy), 0);
        chk("rst cmd", int'(bus.cmd), 0);
        chk("rst arg", int'(bus.arg), 0);
        chk("rst cmd_vld", int'(bus.cmd_vld), 0);
        chk("rst errs", int'({bus.frm_err, bus.to_err, bus.ovr_err}), 0);
        bus.rx_rdy = 1'b0;
        rst = 1'b0;
        idle(1);
        clr_cnt = 0;
        send(8'hA5); idle(9);
        send(8'h01); idle(9);
        send(8'h40); idle(9);
        chk("vld before chk", int'(bus.cmd_vld), 0);
        send(8'h41);
        chk("f1 vld", int'(bus.cmd_vld), 1);
        chk("f1 cmd", int'(bus.cmd), 8'h01);
        chk("f1 arg", int'(bus.arg), 8'h40);
        chk("f1 clr pulses", clr_cnt, 4);
        ack();
        chk("f1 ack clears", int'(bus.cmd_vld), 0);
        chk("f1 cmd held", int'(bus.cmd), 8'h01);
        frame(8'hA5, 8'hFF, 8'h02, 8'h01);
        chk("wrap vld", int'(bus.cmd_vld), 1);
        chk("wrap cmd", int'(bus.cmd), 8'hFF);
        chk("wrap arg", int'(bus.arg), 8'h02);
        frame(8'hA5, 8'h01, 8'h40, 8'h42);
        chk("bad frm_err", int'(bus.frm_err), 1);
        chk("bad vld kept", int'(bus.cmd_vld), 1);
        chk("bad cmd kept", int'(bus.cmd), 8'hFF);
        idle(1);
        chk("frm_err width", frm_cnt, 1);
        ack();
        clr_cnt = 0;
        send(8'h67); send(8'h73); send(8'h00);
        idle(2);
        chk("junk consumed", clr_cnt, 3);
        chk("junk vld", int'(bus.cmd_vld), 0);
        chk("junk cmd", int'(bus.cmd), 8'hFF);
        chk("junk errs", frm_cnt + to_cnt + ovr_cnt, 1);
        frame(8'hA5, 8'hA5, 8'h00, 8'hA5);
        chk("sof data vld", int'(bus.cmd_vld), 1);
        chk("sof data cmd", int'(bus.cmd), 8'hA5);
        chk("sof data arg", int'(bus.arg), 8'h00);
        ack();
        send(8'hA5); send(8'h01);
        idle(15);
        chk("to before", int'(bus.to_err), 0);
        idle(1);
        chk("to pulse", int'(bus.to_err), 1);
        idle(1);
        chk("to width", to_cnt, 1);
        chk("to vld untouched", int'(bus.cmd_vld), 0);
        frame(8'hA5, 8'h10, 8'h20, 8'h30);
        chk("after to vld", int'(bus.cmd_vld), 1);
        chk("after to cmd", int'(bus.cmd), 8'h10);
        ack();
        send(8'hA5); send(8'h01);
        idle(15);
        send(8'h02);
        chk("edge byte no to", int'(bus.to_err), 0);
        send(8'h03);
        chk("edge frame vld", int'(bus.cmd_vld), 1);
        chk("edge frame arg", int'(bus.arg), 8'h02);
        chk("edge to count", to_cnt, 1);
        frame(8'hA5, 8'h04, 8'h05, 8'h09);
        chk("ovr pulse", int'(bus.ovr_err), 1);
        chk("ovr cmd", int'(bus.cmd), 8'h04);
        idle(1);
        chk("ovr width", ovr_cnt, 1);
        send(8'hA5); send(8'h06); send(8'h07);
        bus.cmd_ack = 1'b1;
        send(8'h0D);
        bus.cmd_ack = 1'b0;
        chk("ack load no ovr", int'(bus.ovr_err), 0);
        chk("ack load vld", int'(bus.cmd_vld), 1);
        chk("ack load cmd", int'(bus.cmd), 8'h06);
        idle(2);
        chk("ovr total", ovr_cnt, 1);
        send(8'hA5); send(8'h01); send(8'h40);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid rst vld", int'(bus.cmd_vld), 0);
        chk("mid rst cmd", int'(bus.cmd), 0);
        chk("mid rst arg", int'(bus.arg), 0);
        send(8'h41);
        idle(3);
        chk("trailing byte", int'(bus.cmd_vld), 0);
        chk("trailing errs", int'({bus.frm_err, bus.to_err, bus.ovr_err}), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
